// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: dx = g * y * (1 - y), three-stage valid/ready pipeline.
// Each stage advances independently, so an empty stage fills even while downstream stalls.
module sigmoid_backward #(
    parameter int unsigned INT_BIT  = 7,
    parameter int unsigned FRAC_BIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FRAC_BIT:0]         in_y,
    input  logic [INT_BIT+FRAC_BIT:0] in_g,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_BIT+FRAC_BIT:0] out_dx,
    output logic                      busy
);

    localparam int unsigned YW = FRAC_BIT + 1;
    localparam int unsigned GW = INT_BIT + FRAC_BIT + 1;
    localparam int unsigned PW = INT_BIT + 2 * FRAC_BIT + 2;
    localparam logic [YW-1:0] ONE = {1'b1, {FRAC_BIT{1'b0}}};

    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic [FRAC_BIT-1:0]  r_d;
    logic [GW-1:0]        r_g;
    logic signed [PW-1:0] r_p;
    logic [GW-1:0]        r_dx;

    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_adv3;
    logic                 w_in_xfer;
    logic [YW-1:0]        w_yc;
    logic [YW-1:0]        w_ym;
    logic [2*YW-1:0]      w_yy;
    logic signed [PW-1:0] w_g_ext;
    logic signed [PW-1:0] w_d_ext;

    // Backpressure ripples combinationally from the output toward in_ready.
    assign w_adv3    = !r_v3 | out_ready;
    assign w_adv2    = !r_v2 | w_adv3;
    assign w_adv1    = !r_v1 | w_adv2;
    assign in_ready  = w_adv1 & !flush;
    assign w_in_xfer = in_valid & in_ready;

    // y above 1.0 is clamped so that (1 - y) never wraps.
    assign w_yc = (in_y > ONE) ? ONE : in_y;
    assign w_ym = ONE - w_yc;
    assign w_yy = {{YW{1'b0}}, w_yc} * {{YW{1'b0}}, w_ym};

    assign w_g_ext = {{(PW-GW){r_g[GW-1]}}, r_g};
    assign w_d_ext = PW'({1'b0, r_d});

    assign out_valid = r_v3;
    assign out_dx    = r_dx;
    assign busy      = r_v1 | r_v2 | r_v3;

    // Stage valids; flush empties the whole pipe on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= w_in_xfer;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
        end
    end

    // Stage data; a stalled stage holds its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d  <= '0;
            r_g  <= '0;
            r_p  <= '0;
            r_dx <= '0;
        end else begin
            if (w_in_xfer) begin
                r_d <= FRAC_BIT'(w_yy >> FRAC_BIT);
                r_g <= in_g;
            end
            if (w_adv2) r_p  <= w_g_ext * w_d_ext;
            if (w_adv3) r_dx <= GW'(r_p >>> FRAC_BIT);
        end
    end

endmodule

// File: tb/tb_sigmoid_backward.sv
// Scoreboarded bench for sigmoid_backward: the driver queues hand-computed results on
// each accepted input, and an independent monitor checks every output transfer in order.
module tb_sigmoid_backward;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_y;
    logic [15:0] in_g;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_dx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] held;

    sigmoid_backward #(.INT_BIT(7), .FRAC_BIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_g(in_g),
        .out_valid(out_valid), .out_ready(out_ready), .out_dx(out_dx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end
    endtask

    // Output monitor: pops one expected value per output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%04h, expected none", out_dx);
            end else begin
                chk("out_dx", out_dx, exp_q.pop_front());
            end
        end
    end

    // Present a pair until accepted; called and returns at posedge+1.
    task automatic send(input logic [8:0] y, input logic [15:0] g, input logic [15:0] e);
        int waited = 0;
        in_valid = 1'b1;
        in_y     = y;
        in_g     = g;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 16'd0, 16'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("drain_done", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_y = '0; in_g = '0;
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_out_dx", out_dx, 16'h0000);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // 1: latency of three edges from input transfer to out_valid
        send(9'h080, 16'h0100, 16'h0040);
        @(negedge clk); chk("lat_c1", 16'(out_valid), 16'd0);
        @(negedge clk); chk("lat_c2", 16'(out_valid), 16'd0);
        @(negedge clk); chk("lat_c3", 16'(out_valid), 16'd1);
        @(posedge clk); #1;

        // 2, 3 and floor/extreme cases, back-to-back
        send(9'h0C0, 16'hFF00, 16'hFFD0);
        send(9'h0C0, 16'h0200, 16'h0060);
        send(9'h100, 16'h7FFF, 16'h0000);
        send(9'h1FF, 16'h7FFF, 16'h0000);
        send(9'h000, 16'h7FFF, 16'h0000);
        send(9'h080, 16'h7FFF, 16'h1FFF);
        send(9'h080, 16'h8000, 16'hE000);
        send(9'h080, 16'hFFFF, 16'hFFFF);
        send(9'h0C0, 16'h0001, 16'h0000);
        send(9'h0C0, 16'hFFFF, 16'hFFFF);
        send(9'h040, 16'h0100, 16'h0030);
        drain();
        chk("idle_busy", 16'(busy), 16'd0);

        // 4: stall with three queued, then stream the rest
        out_ready = 1'b0;
        send(9'h080, 16'h0100, 16'h0040);
        send(9'h080, 16'h0200, 16'h0080);
        send(9'h080, 16'h0300, 16'h00C0);
        in_valid = 1'b1; in_y = 9'h080; in_g = 16'h0400;
        @(negedge clk);
        chk("full_in_ready", 16'(in_ready), 16'd0);
        chk("full_out_valid", 16'(out_valid), 16'd1);
        held = out_dx;
        chk("stall_head", held, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", out_dx, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(9'h080, 16'h0400, 16'h0100);
        send(9'h080, 16'h0500, 16'h0140);
        send(9'h080, 16'hFC00, 16'hFF00);
        send(9'h0C0, 16'h0100, 16'h0030);
        send(9'h0C0, 16'hFE00, 16'hFFA0);
        drain();

        // 5: gapped input with output stalled fills all three stages
        out_ready = 1'b0;
        send(9'h080, 16'h0100, 16'h0040);
        idle(2);
        send(9'h0C0, 16'h0200, 16'h0060);
        idle(1);
        send(9'h080, 16'hFF00, 16'hFFC0);
        @(negedge clk);
        chk("gap_in_ready", 16'(in_ready), 16'd0);
        chk("gap_busy", 16'(busy), 16'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        chk("gap_busy_end", 16'(busy), 16'd0);

        // 6a: flush with three in flight and a pending input
        out_ready = 1'b0;
        send(9'h080, 16'h0100, 16'h0040);
        send(9'h080, 16'h0200, 16'h0080);
        send(9'h080, 16'h0300, 16'h00C0);
        in_valid = 1'b1; in_y = 9'h080; in_g = 16'h0700; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 16'(in_ready), 16'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_busy", 16'(busy), 16'd0);
        chk("flush_out_valid", 16'(out_valid), 16'd0);
        out_ready = 1'b1;
        idle(6);

        // 6b: asynchronous reset mid-stream
        out_ready = 1'b0;
        send(9'h080, 16'h0100, 16'h0040);
        send(9'h0C0, 16'h0200, 16'h0060);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 16'(out_valid), 16'd0);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_out_dx", out_dx, 16'h0000);
        exp_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(9'h0C0, 16'hFF00, 16'hFFD0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
